// File: rtl/divider_datapath.sv
// Datapath of the 32-bit unsigned restoring divider: one subtract-and-shift per qualifying cycle, result after 1 load + 32 iterations + 1 shift.
// No backpressure; control strobes are consumed one per clock and out-of-sequence shifts raise sticky Seq_err.
module divider_datapath (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Load,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
    input  logic        W_ctrl,
    input  logic [5:0]  SUBU_ctrl,
    input  logic        SRL_ctrl,
    output logic [31:0] Quotient,
    output logic [31:0] Remainder,
    output logic [5:0]  Iter,
    output logic        Done,
    output logic        DivByZero,
    output logic        Seq_err
);

    localparam logic [5:0] SUBU_FN   = 6'b001010;
    localparam logic [5:0] LAST_ITER = 6'd32;

    logic [64:0] rem_q;
    logic [31:0] div_q;
    logic [31:0] diff_lo;
    logic        borrow;
    logic        iter_fire;
    logic        srl_ok;

    // Compare on the full 33-bit upper field so divisors >= 2^31 work; only the
    // low 32 bits of the difference are kept since the remainder is < divisor.
    always_comb begin
        borrow    = rem_q[64:32] < {1'b0, div_q};
        diff_lo   = rem_q[63:32] - div_q;
        iter_fire = W_ctrl && (SUBU_ctrl == SUBU_FN) && (Iter < LAST_ITER) && !Done;
        srl_ok    = (Iter == LAST_ITER) && !Done;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            rem_q     <= '0;
            div_q     <= '0;
            Iter      <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            Seq_err   <= 1'b0;
        end else if (Load) begin
            rem_q     <= {32'b0, Dividend, 1'b0};
            div_q     <= Divisor;
            Iter      <= '0;
            Done      <= 1'b0;
            Seq_err   <= 1'b0;
            DivByZero <= (Divisor == 32'b0);
        end else if (SRL_ctrl) begin
            if (srl_ok) begin
                rem_q[64:32] <= {1'b0, rem_q[64:33]};
                Done         <= 1'b1;
            end else begin
                Seq_err <= 1'b1;
            end
        end else if (iter_fire) begin
            if (borrow) begin
                rem_q <= {rem_q[63:0], 1'b0};
            end else begin
                rem_q <= {diff_lo, rem_q[31:0], 1'b1};
            end
            Iter <= Iter + 6'd1;
        end
    end

    assign Quotient  = rem_q[31:0];
    assign Remainder = rem_q[63:32];

endmodule

// File: tb/tb_divider_datapath.sv
// Directed-vector bench for divider_datapath with hand-computed expected results.
module tb_divider_datapath;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Load = 1'b0;
    logic [31:0] Dividend = '0;
    logic [31:0] Divisor = '0;
    logic        W_ctrl = 1'b0;
    logic [5:0]  SUBU_ctrl = '0;
    logic        SRL_ctrl = 1'b0;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic [5:0]  Iter;
    logic        Done;
    logic        DivByZero;
    logic        Seq_err;

    int n_vec = 0;
    int n_err = 0;

    divider_datapath dut (
        .clk       (clk),
        .Reset     (Reset),
        .Load      (Load),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .W_ctrl    (W_ctrl),
        .SUBU_ctrl (SUBU_ctrl),
        .SRL_ctrl  (SRL_ctrl),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Iter      (Iter),
        .Done      (Done),
        .DivByZero (DivByZero),
        .Seq_err   (Seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] b);
        Load = 1'b1; Dividend = a; Divisor = b;
        step();
        Load = 1'b0;
    endtask

    task automatic run_iters(input int n);
        W_ctrl = 1'b1; SUBU_ctrl = 6'b001010;
        repeat (n) step();
        W_ctrl = 1'b0; SUBU_ctrl = '0;
    endtask

    task automatic do_srl();
        SRL_ctrl = 1'b1;
        step();
        SRL_ctrl = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [31:0] q, input logic [31:0] r);
        chk({tag, "_quo"}, Quotient, q);
        chk({tag, "_rem"}, Remainder, r);
        chk({tag, "_done"}, {31'b0, Done}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_quo"}, Quotient, 32'd0);
        chk({tag, "_rem"}, Remainder, 32'd0);
        chk({tag, "_iter"}, {26'b0, Iter}, 32'd0);
        chk({tag, "_done"}, {31'b0, Done}, 32'd0);
        chk({tag, "_dbz"}, {31'b0, DivByZero}, 32'd0);
        chk({tag, "_seq"}, {31'b0, Seq_err}, 32'd0);
    endtask

    initial begin
        #1;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk_all_zero("reset");

        // 100 / 7 = 14 r 2
        do_load(32'd100, 32'd7);
        chk("l100_iter", {26'b0, Iter}, 32'd0);
        chk("l100_shifted", Quotient, 32'd200);
        run_iters(32);
        chk("d100_iter32", {26'b0, Iter}, 32'd32);
        chk("d100_notdone", {31'b0, Done}, 32'd0);
        do_srl();
        chk_result("d100", 32'd14, 32'd2);
        chk("d100_dbz", {31'b0, DivByZero}, 32'd0);
        chk("d100_seq", {31'b0, Seq_err}, 32'd0);
        run_iters(3);
        chk("d100_hold_iter", {26'b0, Iter}, 32'd32);
        chk("d100_hold_quo", Quotient, 32'd14);
        do_srl();
        chk("d100_late_srl_seq", {31'b0, Seq_err}, 32'd1);
        chk("d100_late_srl_rem", Remainder, 32'd2);

        // Large divisor exercises the 33-bit compare
        do_load(32'h80000001, 32'h80000000);
        chk("big_load_clr_seq", {31'b0, Seq_err}, 32'd0);
        run_iters(32);
        do_srl();
        chk_result("big", 32'd1, 32'd1);

        do_load(32'hFFFFFFFF, 32'd1);
        run_iters(32);
        do_srl();
        chk_result("by1", 32'hFFFFFFFF, 32'd0);

        do_load(32'd1234, 32'd0);
        chk("dz_flag_at_load", {31'b0, DivByZero}, 32'd1);
        run_iters(32);
        do_srl();
        chk_result("dz", 32'hFFFFFFFF, 32'd1234);
        chk("dz_flag", {31'b0, DivByZero}, 32'd1);

        // Non-subtract ALU function is a no-op
        do_load(32'd50, 32'd3);
        chk("d50_dbz_clr", {31'b0, DivByZero}, 32'd0);
        W_ctrl = 1'b1; SUBU_ctrl = 6'b000000;
        repeat (10) step();
        W_ctrl = 1'b0;
        chk("nop_iter", {26'b0, Iter}, 32'd0);
        chk("nop_quo", Quotient, 32'd100);
        chk("nop_rem", Remainder, 32'd0);
        run_iters(32);
        do_srl();
        chk_result("d50", 32'd16, 32'd2);

        // Early shift request: sticky error, iteration count untouched
        do_load(32'd9, 32'd2);
        run_iters(10);
        W_ctrl = 1'b1; SUBU_ctrl = 6'b001010; SRL_ctrl = 1'b1;
        step();
        SRL_ctrl = 1'b0; W_ctrl = 1'b0;
        chk("early_seq", {31'b0, Seq_err}, 32'd1);
        chk("early_iter", {26'b0, Iter}, 32'd10);
        chk("early_done", {31'b0, Done}, 32'd0);
        run_iters(22);
        do_srl();
        chk_result("d9", 32'd4, 32'd1);
        chk("d9_seq_sticky", {31'b0, Seq_err}, 32'd1);

        // Load beats a simultaneous shift, then abort mid-division
        SRL_ctrl = 1'b1;
        do_load(32'd7, 32'd2);
        SRL_ctrl = 1'b0;
        chk("ldsrl_seq", {31'b0, Seq_err}, 32'd0);
        chk("ldsrl_iter", {26'b0, Iter}, 32'd0);
        run_iters(5);
        chk("abort_pre_iter", {26'b0, Iter}, 32'd5);
        do_load(32'd20, 32'd3);
        chk("abort_iter", {26'b0, Iter}, 32'd0);
        run_iters(32);
        do_srl();
        chk_result("d20", 32'd6, 32'd2);

        // Reset mid-operation with W_ctrl held high
        do_load(32'd1000, 32'd0);
        run_iters(16);
        chk("mid_iter16", {26'b0, Iter}, 32'd16);
        W_ctrl = 1'b1; SUBU_ctrl = 6'b001010; Reset = 1'b1;
        step();
        Reset = 1'b0; W_ctrl = 1'b0;
        chk_all_zero("midrst");
        run_iters(1);
        chk("post_rst_iter", {26'b0, Iter}, 32'd1);
        chk("post_rst_quo", Quotient, 32'd1);
        run_iters(31);
        do_srl();
        chk_result("zero", 32'hFFFFFFFF, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
